// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register map,
// CTRL bit layout, mode encodings and the FSM state type.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_if.sv
// Bridge-side bus of one timer: decoded word address, qualified write,
// write/read data and the interrupt line.
interface timer_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        IRQ;

    modport master (output Addr, output WE, output DataIn, input DataOut, input IRQ);
    modport slave  (input Addr, input WE, input DataIn, output DataOut, output IRQ);
endinterface

// File: rtl/timer_device.sv
// Down-counting timer with CTRL/PRESET/COUNT registers, a 4-state FSM and a
// maskable interrupt. The system top instantiates two of these (Timer0/1).
module timer_device
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    timer_if.slave bus
);

    logic [3:0]       ctrl_reg;
    logic [CNT_W-1:0] preset_reg;
    logic [CNT_W-1:0] count_reg;
    state_t           state_reg;
    logic             irq_pend_reg;

    logic en;
    logic reload;
    logic wr_ctrl;
    logic wr_preset;

    assign en        = ctrl_reg[CTRL_EN];
    assign reload    = (ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign wr_ctrl   = bus.WE && (bus.Addr == ADDR_CTRL);
    assign wr_preset = bus.WE && (bus.Addr == ADDR_PRESET);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg     <= '0;
            preset_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            irq_pend_reg <= 1'b0;
        end else begin
            // Clears come first so the INT-state set below overrides them.
            if (wr_ctrl || wr_preset || (reload && state_reg != ST_INT))
                irq_pend_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (en)
                        state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en)
                        state_reg <= ST_IDLE;
                    else if (count_reg != '0)
                        count_reg <= count_reg - CNT_W'(1);
                    else
                        state_reg <= ST_INT;
                end
                ST_INT: begin
                    irq_pend_reg <= 1'b1;
                    if (reload) begin
                        state_reg <= ST_LOAD;
                    end else begin
                        state_reg         <= ST_IDLE;
                        ctrl_reg[CTRL_EN] <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // CPU writes are placed last so a CTRL write beats the hardware EN clear.
            if (wr_ctrl)
                ctrl_reg <= bus.DataIn[3:0];
            if (wr_preset)
                preset_reg <= bus.DataIn[CNT_W-1:0];
        end
    end

    always_comb begin
        bus.DataOut = 32'b0;
        case (bus.Addr)
            ADDR_CTRL:   bus.DataOut = {28'b0, ctrl_reg};
            ADDR_PRESET: bus.DataOut = 32'(preset_reg);
            ADDR_COUNT:  bus.DataOut = 32'(count_reg);
            default:     bus.DataOut = 32'b0;
        endcase
    end

    assign bus.IRQ = irq_pend_reg & ctrl_reg[CTRL_IM];

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: a vector table for reset and the one-shot
// run, then hand-written sequences for reload, pause, masking and reset abort.
module tb_timer_device;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    timer_if bus ();

    timer_device #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_dout;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[19];

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.WE     = we;
        bus.Addr   = a;
        bus.DataIn = d;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Poll COUNT until it shows target; an expired budget is reported as a failure.
    task automatic wait_count(input string name, input logic [31:0] target, input int budget);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            if (bus.DataOut == target) found = 1'b1;
        end
        chk(name, {31'b0, found}, 32'd1);
    endtask

    initial begin
        bus.WE = 1'b0; bus.Addr = 2'd0; bus.DataIn = 32'd0;

        vecs[0]  = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b0, "rst_ctrl"};
        vecs[1]  = '{1'b0, 2'd1, 32'd0, 32'd0, 1'b0, "rst_preset"};
        vecs[2]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, "rst_count"};
        vecs[3]  = '{1'b0, 2'd3, 32'd0, 32'd0, 1'b0, "rst_rsvd"};
        vecs[4]  = '{1'b1, 2'd1, 32'd5, 32'd0, 1'b0, "wr_preset5"};
        vecs[5]  = '{1'b1, 2'd0, 32'd9, 32'd0, 1'b0, "wr_ctrl9"};
        vecs[6]  = '{1'b0, 2'd0, 32'd0, 32'd9, 1'b0, "rd_ctrl9"};
        vecs[7]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, "load_cycle"};
        vecs[8]  = '{1'b0, 2'd2, 32'd0, 32'd5, 1'b0, "count5"};
        vecs[9]  = '{1'b0, 2'd2, 32'd0, 32'd4, 1'b0, "count4"};
        vecs[10] = '{1'b0, 2'd2, 32'd0, 32'd3, 1'b0, "count3"};
        vecs[11] = '{1'b0, 2'd2, 32'd0, 32'd2, 1'b0, "count2"};
        vecs[12] = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b0, "count1"};
        vecs[13] = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, "count0"};
        vecs[14] = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, "int_state"};
        vecs[15] = '{1'b0, 2'd0, 32'd0, 32'd8, 1'b1, "irq_en_cleared"};
        vecs[16] = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b1, "irq_sticky"};
        vecs[17] = '{1'b1, 2'd1, 32'd7, 32'd5, 1'b1, "wr_preset7"};
        vecs[18] = '{1'b0, 2'd1, 32'd0, 32'd7, 1'b0, "irq_dropped"};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and one-shot run
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data);
            chk({vecs[i].name, "_dout"}, bus.DataOut, vecs[i].exp_dout);
            chk({vecs[i].name, "_irq"}, {31'b0, bus.IRQ}, {31'b0, vecs[i].exp_irq});
        end

        // Auto-reload, PRESET=3: pulse every 6 cycles, COUNT=3 right after each pulse
        drive(1'b1, 2'd1, 32'd3);
        drive(1'b1, 2'd0, 32'hB);
        for (int k = 1; k <= 28; k++) begin
            logic exp_irq;
            drive(1'b0, 2'd2, 32'd0);
            exp_irq = (k >= 8) && (((k - 8) % 6) == 0);
            chk($sformatf("reload_irq_k%0d", k), {31'b0, bus.IRQ}, {31'b0, exp_irq});
            if (k >= 9 && ((k - 9) % 6) == 0)
                chk($sformatf("reload_count_k%0d", k), bus.DataOut, 32'd3);
        end
        drive(1'b1, 2'd0, 32'd0);
        repeat (4) drive(1'b0, 2'd0, 32'd0);

        // Pause at 6, then restart from PRESET=10
        drive(1'b1, 2'd1, 32'd10);
        drive(1'b1, 2'd0, 32'd9);
        wait_count("pause_wait10", 32'd10, 10);
        wait_count("pause_wait7", 32'd7, 10);
        bus.WE = 1'b1; bus.Addr = 2'd0; bus.DataIn = 32'd0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            chk($sformatf("frozen_k%0d", k), bus.DataOut, 32'd6);
            chk($sformatf("frozen_irq_k%0d", k), {31'b0, bus.IRQ}, 32'd0);
        end
        drive(1'b1, 2'd0, 32'd9);
        for (int k = 1; k <= 15; k++) begin
            logic [31:0] exp_cnt;
            drive(1'b0, 2'd2, 32'd0);
            exp_cnt = (k < 3) ? 32'd6 : (k <= 13) ? 32'(13 - k) : 32'd0;
            chk($sformatf("restart_count_k%0d", k), bus.DataOut, exp_cnt);
            chk($sformatf("restart_irq_k%0d", k), {31'b0, bus.IRQ}, {31'b0, (k == 15)});
        end

        // Masked expiry, pending cleared by a CTRL write, COUNT write ignored
        drive(1'b1, 2'd1, 32'd2);
        drive(1'b1, 2'd0, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 2'd2, 32'd0);
            chk($sformatf("masked_irq_k%0d", k), {31'b0, bus.IRQ}, 32'd0);
        end
        drive(1'b0, 2'd0, 32'd0);
        chk("masked_en_cleared", bus.DataOut, 32'd0);
        drive(1'b1, 2'd0, 32'd8);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 2'd0, 32'd0);
            chk($sformatf("pend_cleared_irq_k%0d", k), {31'b0, bus.IRQ}, 32'd0);
        end
        chk("ctrl_im_only", bus.DataOut, 32'd8);
        drive(1'b1, 2'd2, 32'hFFFF);
        drive(1'b0, 2'd2, 32'd0);
        chk("count_wr_ignored", bus.DataOut, 32'd0);
        drive(1'b1, 2'd3, 32'hFFFF);
        drive(1'b0, 2'd3, 32'd0);
        chk("rsvd_reads_zero", bus.DataOut, 32'd0);

        // Reset mid-count at COUNT=4
        drive(1'b1, 2'd1, 32'd10);
        drive(1'b1, 2'd0, 32'd9);
        wait_count("rst_wait10", 32'd10, 10);
        wait_count("rst_wait4", 32'd4, 10);
        reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0);
        reset = 1'b0;
        chk("midrst_ctrl", bus.DataOut, 32'd0);
        chk("midrst_irq", {31'b0, bus.IRQ}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 2'(k % 4), 32'd0);
            chk($sformatf("midrst_rd_k%0d", k), bus.DataOut, 32'd0);
            chk($sformatf("midrst_irq_k%0d", k), {31'b0, bus.IRQ}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
